// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multi-cycle ALU.
//   - 4-bit operation codes driven on mc_alu.control
//   - FSM state encoding used by mc_alu
//   - helper to classify codes handled by the combinational core
package alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;
   localparam logic [3:0] OP_MUL = 4'b1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Codes that go through the shared adder with b inverted and carry-in set.
   function automatic logic uses_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SLT);
   endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU datapath (everything except MUL).
// Ports:
//   a, b      in  WIDTH  operands
//   control   in  4      operation code (alu_pkg OP_*)
//   result    out WIDTH  operation result (0 for MUL / illegal codes)
//   cout      out 1      adder carry-out for ADD/SUB/SLT
//   overflow  out 1      signed overflow for ADD/SUB
//   illegal   out 1      code is not a recognised operation
// OP_MUL is recognised (illegal=0) but produces 0 here; the owner of this
// core runs the shift-add multiplier itself.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       control,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             illegal
);

   logic             sub;
   logic [WIDTH-1:0] bb;
   logic [WIDTH:0]   sum;
   logic             ovf;

   // One shared adder: SUB and SLT compute a + ~b + 1.
   assign sub = uses_sub(control);
   assign bb  = sub ? ~b : b;
   assign sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};

   // Signed overflow: adder inputs agree in sign, sum sign differs.
   assign ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      result   = '0;
      cout     = 1'b0;
      overflow = 1'b0;
      illegal  = 1'b0;
      case (control)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_NOR: result = ~(a | b);
         OP_ADD, OP_SUB: begin
            result   = sum[WIDTH-1:0];
            cout     = sum[WIDTH];
            overflow = ovf;
         end
         OP_SLT: begin
            // Sign of the true difference is sum MSB corrected by overflow.
            result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            cout   = sum[WIDTH];
         end
         OP_MUL: result = '0;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete on the accepting edge; MUL is a shift-add
// unsigned multiply taking WIDTH cycles. Outputs are registered and held
// stable in DONE until the consumer takes them.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = state is IDLE)
//   a, b, control        operands and operation code
//   out_valid/out_ready  result handshake
//   result, result_hi    low result / high product half (MUL only)
//   zero, cout, overflow flags; illegal = unrecognised code
module mc_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             cout,
   output logic             overflow,
   output logic             illegal
);

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef struct packed {
      logic [WIDTH-1:0] lo;
      logic [WIDTH-1:0] hi;
      logic             zero;
      logic             cout;
      logic             ovf;
      logic             ill;
   } res_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc;     // upper product half plus carry slot
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;  // low product bits shift in from the top
   res_t             res_q;
   logic             vld_q;

   logic [WIDTH-1:0] core_res;
   logic             core_cout, core_ovf, core_ill;

   logic [WIDTH:0]   msum;
   logic [WIDTH-1:0] p_hi, p_lo;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a        (a),
      .b        (b),
      .control  (control),
      .result   (core_res),
      .cout     (core_cout),
      .overflow (core_ovf),
      .illegal  (core_ill)
   );

   // acc[WIDTH] is always 0 after a shift, so the sum fits in WIDTH+1 bits.
   assign msum = acc + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
   // Next {acc, mplier} after shifting {carry, acc, mplier} right by one.
   assign p_hi = msum[WIDTH:1];
   assign p_lo = {msum[0], mplier[WIDTH-1:1]};

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         res_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (control == OP_MUL) begin
                     mcand  <= a;
                     mplier <= b;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= MUL;
                  end else begin
                     res_q.lo   <= core_res;
                     res_q.hi   <= '0;
                     res_q.zero <= (core_res == '0);
                     res_q.cout <= core_cout;
                     res_q.ovf  <= core_ovf;
                     res_q.ill  <= core_ill;
                     vld_q      <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            MUL: begin
               acc    <= {1'b0, p_hi};
               mplier <= p_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  // Capture from the values being shifted in on this edge.
                  res_q.lo   <= p_lo;
                  res_q.hi   <= p_hi;
                  res_q.zero <= (p_lo == '0);
                  res_q.cout <= 1'b0;
                  res_q.ovf  <= |p_hi;
                  res_q.ill  <= 1'b0;
                  vld_q      <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  vld_q <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out_valid = vld_q;
   assign result    = res_q.lo;
   assign result_hi = res_q.hi;
   assign zero      = res_q.zero;
   assign cout      = res_q.cout;
   assign overflow  = res_q.ovf;
   assign illegal   = res_q.ill;

endmodule
